viterbi_dec_param: RTL and testbench

- Parametrised hard-decision Viterbi decoder for a rate-1/2, K=3 (4-state) convolutional code, placed after the QAM demapper in the receive chain.
- Accepts FRAME_LEN 2-bit symbols through a valid/ready handshake and runs one ACS step per accepted symbol.
- At frame end it traces back through the stored survivor decisions and emits FRAME_LEN decoded bits in order through a second valid/ready handshake.
- Generator polynomials, frame length and metric width are parameters; adds flow control, metric normalisation and frame markers.

---
 rtl/viterbi_dec_param.sv | 232 +++++++++++++++++++++++
 tb/tb_viterbi_dec_param.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_dec_param.sv
// -----------------------------------------------------------------------------
// viterbi_dec_param
//
// Hard-decision Viterbi decoder for a rate-1/2, K=3 (4-state) convolutional
// code. It accepts FRAME_LEN 2-bit symbols and runs one add-compare-select step
// per accepted symbol. It then traces back through the stored survivor
// decisions and streams FRAME_LEN decoded bits out in order.
//
// Code convention: state s = {u[n-1], u[n-2]}, shift register r = {u, s}.
//   c0 = ^(r & G0), c1 = ^(r & G1), next state = {u, s[1]}.
//
// Parameters:
//   FRAME_LEN  symbols (and decoded bits) per frame, 4..256
//   MW         path-metric width, >= 4
//   G0, G1     generator polynomials for c0 / c1 (bit 2 taps the current input)
//
// Compile-time option:
//   VIT_TERM_EN  defined   : frames are tail-terminated, so traceback starts in state 0
//                undefined : traceback starts in the state with the lowest final
//                            metric (ties go to the lowest state index)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   symbol valid
//   in_ready   decoder accepts a symbol (ACS phase only)
//   in_sym     [1]=c0, [0]=c1 hard bits from the demapper
//   out_valid  decoded bit valid (OUT phase)
//   out_ready  sink accepts the bit
//   out_bit    decoded bit
//   out_last   high with the final bit of a frame
//   busy       high while in traceback or output phase
// -----------------------------------------------------------------------------
module viterbi_dec_param #(
  parameter int         FRAME_LEN = 31,
  parameter int         MW        = 8,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_sym,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy
);

  localparam int              TW      = $clog2(FRAME_LEN);
  localparam logic [TW-1:0]   T_LAST  = TW'(FRAME_LEN - 1);
  localparam logic [MW-1:0]   PM_MAX  = '1;
  // Non-zero states start with a large handicap so decoding favours state 0.
  localparam logic [MW-1:0]   PM_INIT = {2'b01, {(MW-2){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACS,
    ST_TB,
    ST_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q;
  logic [TW-1:0]   k_q;
  logic [1:0]      tb_s_q;
  logic [MW-1:0]   pm_q [4];
  logic [3:0]      surv_q [FRAME_LEN];
  logic [FRAME_LEN-1:0] obuf_q;

  logic            sym_fire;
  logic            out_fire;

  logic [MW-1:0]   cand0 [4];
  logic [MW-1:0]   cand1 [4];
  logic [MW-1:0]   acs_pm [4];
  logic [MW-1:0]   pm_norm [4];
  logic [MW-1:0]   acs_min;
  logic [3:0]      acs_dec;
  logic [1:0]      start_state;

  // Hamming distance between the received symbol and the code word emitted
  // when input u is shifted into predecessor state ps.
  function automatic logic [1:0] branch_metric(input logic [1:0] ps,
                                               input logic       u,
                                               input logic [1:0] sym);
    logic [2:0] r;
    logic       c0;
    logic       c1;
    r  = {u, ps};
    c0 = ^(r & G0);
    c1 = ^(r & G1);
    branch_metric = {1'b0, sym[1] ^ c0} + {1'b0, sym[0] ^ c1};
  endfunction

  function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] a,
                                            input logic [1:0]    b);
    logic [MW:0] s;
    s       = {1'b0, a} + {{(MW-1){1'b0}}, b};
    sat_add = s[MW] ? PM_MAX : s[MW-1:0];
  endfunction

  function automatic logic [MW-1:0] pm_start(input int idx);
    pm_start = (idx == 0) ? '0 : PM_INIT;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshakes and outputs. Gating with reset keeps every output quiet during
  // the reset cycle, whatever state the register held before.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state_q == ST_ACS) && !reset;
  assign out_valid = (state_q == ST_OUT) && !reset;
  assign busy      = (state_q != ST_ACS) && !reset;
  assign out_bit   = out_valid && obuf_q[k_q];
  assign out_last  = out_valid && (k_q == T_LAST);

  assign sym_fire  = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Add-compare-select with same-cycle normalisation.
  // Next state ns = {u, p} is reached from {p,0} (cand0) or {p,1} (cand1).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a value before any conditional logic, so no
    // path through this block can leave one unassigned and infer a latch.
    acs_dec = '0;
    acs_min = '0;
    for (int i = 0; i < 4; i++) begin
      cand0[i]   = sat_add(pm_q[{i[0], 1'b0}], branch_metric({i[0], 1'b0}, i[1], in_sym));
      cand1[i]   = sat_add(pm_q[{i[0], 1'b1}], branch_metric({i[0], 1'b1}, i[1], in_sym));
      // Ties keep the {p,0} predecessor.
      acs_dec[i] = (cand1[i] < cand0[i]);
      acs_pm[i]  = acs_dec[i] ? cand1[i] : cand0[i];
    end
    acs_min = acs_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (acs_pm[i] < acs_min) acs_min = acs_pm[i];
    end
    for (int i = 0; i < 4; i++) begin
      pm_norm[i] = acs_pm[i] - acs_min;
    end
  end

  // Traceback start state, taken from the metrics produced by the last step.
`ifdef VIT_TERM_EN
  assign start_state = 2'd0;
`else
  logic [MW-1:0] best_pm;
  always_comb begin
    start_state = 2'd0;
    best_pm     = pm_norm[0];
    for (int i = 1; i < 4; i++) begin
      // Strict compare: equal metrics keep the lower state index.
      if (pm_norm[i] < best_pm) begin
        best_pm     = pm_norm[i];
        start_state = 2'(i);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: ACS -> TB -> OUT -> ACS
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff block samples the pre-edge values, independent of block order.
    if (reset) state_q <= ST_ACS;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACS:  if (sym_fire && (t_q == T_LAST)) state_d = ST_TB;
      ST_TB:   if (t_q == '0) state_d = ST_OUT;
      ST_OUT:  if (out_fire && (k_q == T_LAST)) state_d = ST_ACS;
      default: state_d = ST_ACS;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: metrics, survivor store, traceback and output buffer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      t_q    <= '0;
      k_q    <= '0;
      tb_s_q <= '0;
      obuf_q <= '0;
      for (int i = 0; i < 4; i++) pm_q[i] <= pm_start(i);
      // NOTE: the survivor store is a register array, so clearing it on reset
      // is cheap and keeps a partial frame from ever leaking into a traceback.
      for (int i = 0; i < FRAME_LEN; i++) surv_q[i] <= '0;
    end else begin
      case (state_q)
        ST_ACS: begin
          if (sym_fire) begin
            surv_q[t_q] <= acs_dec;
            for (int i = 0; i < 4; i++) pm_q[i] <= pm_norm[i];
            // On the last symbol t stays at FRAME_LEN-1, where traceback begins.
            if (t_q == T_LAST) tb_s_q <= start_state;
            else               t_q    <= t_q + 1'b1;
          end
        end
        ST_TB: begin
          // s[1] is the input bit that led into s; the decision bit completes
          // the predecessor {s[0], d}.
          obuf_q[t_q] <= tb_s_q[1];
          tb_s_q      <= {tb_s_q[0], surv_q[t_q][tb_s_q]};
          if (t_q != '0) t_q <= t_q - 1'b1;
          k_q <= '0;
        end
        ST_OUT: begin
          if (out_fire) begin
            if (k_q == T_LAST) begin
              k_q <= '0;
              t_q <= '0;
              for (int i = 0; i < 4; i++) pm_q[i] <= pm_start(i);
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_dec_param.sv
// -----------------------------------------------------------------------------
// tb_viterbi_dec_param
//
// Bench for viterbi_dec_param. A driver feeds frames (fixed and random, with
// and without channel errors, with input gaps) while the sink's out_ready
// follows a selectable pattern. A behavioural Viterbi model computes every
// expected bit; one negedge monitor checks the DUT against that model and
// against the frame-level timing (busy window, latency, stall stability).
// -----------------------------------------------------------------------------
module tb_viterbi_dec_param;

  localparam int         FL = 31;
  localparam int         MW = 8;
  localparam bit   [2:0] G0 = 3'b111;
  localparam bit   [2:0] G1 = 3'b101;

  typedef bit [1:0] sym_t;
  typedef sym_t     frame_t [FL];
  typedef bit       bits_t  [FL];
  typedef struct {
    bit b;
    bit last;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sym;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_last;
  logic       busy;

  int   n_checks;
  int   n_fail;
  int   cyc;
  int   rdy_mode;
  int   rdy_ph;

  exp_t exp_q[$];
  bit   exp_busy;
  bit   first_pending;
  int   acc_cnt;
  int   last_acc;
  bit   prev_stall;
  logic prev_bit;
  logic prev_last;

  viterbi_dec_param #(
    .FRAME_LEN (FL),
    .MW        (MW),
    .G0        (G0),
    .G1        (G1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: encoder and Viterbi decoder on plain integers.
  // ---------------------------------------------------------------------------
  function automatic int parity_taps(input bit [2:0] g, input int u, input int s);
    int r;
    int p;
    r = (u << 2) | s;
    p = 0;
    for (int b = 0; b < 3; b++) begin
      if (g[b]) p = p ^ ((r >> b) & 1);
    end
    return p;
  endfunction

  function automatic int code_word(input int s, input int u);
    return (parity_taps(G0, u, s) << 1) | parity_taps(G1, u, s);
  endfunction

  function automatic int hamming2(input int a, input int b);
    int x;
    x = (a ^ b) & 3;
    return (x & 1) + ((x >> 1) & 1);
  endfunction

  function automatic void conv_encode(input bits_t u, output frame_t y);
    int s;
    s = 0;
    for (int t = 0; t < FL; t++) begin
      y[t] = 2'(code_word(s, int'(u[t])));
      s    = (int'(u[t]) << 1) | (s >> 1);
    end
  endfunction

  function automatic void model_decode(input frame_t y, output bits_t d_out);
    int       pm [4];
    int       npm [4];
    bit [3:0] dec [FL];
    int       maxv;
    int       mn;
    int       s;
    int       ca;
    int       cb;
    maxv  = (1 << MW) - 1;
    pm[0] = 0;
    for (int i = 1; i < 4; i++) pm[i] = 1 << (MW - 2);
    for (int t = 0; t < FL; t++) begin
      for (int ns = 0; ns < 4; ns++) begin
        // ns = {u, p}; candidates come from states 2p and 2p+1.
        ca = pm[2 * (ns & 1)]     + hamming2(int'(y[t]), code_word(2 * (ns & 1),     ns >> 1));
        cb = pm[2 * (ns & 1) + 1] + hamming2(int'(y[t]), code_word(2 * (ns & 1) + 1, ns >> 1));
        if (ca > maxv) ca = maxv;
        if (cb > maxv) cb = maxv;
        if (cb < ca) begin
          npm[ns]    = cb;
          dec[t][ns] = 1'b1;
        end else begin
          npm[ns]    = ca;
          dec[t][ns] = 1'b0;
        end
      end
      mn = npm[0];
      for (int i = 1; i < 4; i++) if (npm[i] < mn) mn = npm[i];
      for (int i = 0; i < 4; i++) pm[i] = npm[i] - mn;
    end
`ifdef VIT_TERM_EN
    s = 0;
`else
    s = 0;
    for (int i = 1; i < 4; i++) if (pm[i] < pm[s]) s = i;
`endif
    for (int t = FL - 1; t >= 0; t--) begin
      d_out[t] = bit'(s >> 1);
      s        = ((s & 1) << 1) | int'(dec[t][s]);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver helpers (all start and end at posedge + 1).
  // ---------------------------------------------------------------------------
  task automatic send_sym(input sym_t s);
    bit got;
    int n;
    in_valid = 1'b1;
    in_sym   = s;
    got      = 1'b0;
    n        = 0;
    while (!got && n < 1000) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("in_handshake", got, 1);
  endtask

  task automatic push_expected(input frame_t y);
    bits_t b;
    exp_t  e;
    model_decode(y, b);
    for (int i = 0; i < FL; i++) begin
      e.b    = b[i];
      e.last = (i == FL - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input frame_t y, input int gmin, input int gmax);
    int gap;
    for (int i = 0; i < FL; i++) begin
      send_sym(y[i]);
      if (i == FL - 1) push_expected(y);
      gap = $urandom_range(gmax, gmin);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_done", (exp_q.size() == 0) && !exp_busy, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sink back-pressure: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    bit [3:0] pat;
    #1;
    pat = 4'b1001;
    case (rdy_mode)
      1: begin
        out_ready = pat[3 - rdy_ph];
        rdy_ph    = (rdy_ph + 1) % 4;
      end
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares the DUT against the model every cycle.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("reset_in_ready",  in_ready,  0);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy",      busy,      0);
      acc_cnt       = 0;
      exp_busy      = 1'b0;
      first_pending = 1'b0;
      prev_stall    = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_bit",   out_bit,   prev_bit);
        check("stall_hold_last",  out_last,  prev_last);
      end
      check("in_ready_phase", in_ready, !exp_busy);
      check("busy_phase",     busy,     exp_busy);
      if (!exp_busy) check("out_valid_idle", out_valid, 0);
      if (out_valid && first_pending) begin
        check("first_out_latency", cyc - last_acc, FL + 1);
        first_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_bit",  out_bit,  e.b);
          check("out_last", out_last, e.last);
          if (e.last) exp_busy = 1'b0;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_bit   = out_bit;
      prev_last  = out_last;
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (acc_cnt == FL) begin
          acc_cnt       = 0;
          exp_busy      = 1'b1;
          last_acc      = cyc;
          first_pending = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bits_t  info;
    bits_t  dec_bits;
    bits_t  zero_bits;
    frame_t zero_frame;
    frame_t known_frame;
    frame_t err_frame;
    frame_t rnd_frame;
    sym_t   lit_syms [7];

    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    rdy_mode  = 0;
    rdy_ph    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sym    = 2'b00;
    out_ready = 1'b1;

    lit_syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
    for (int i = 0; i < FL; i++) begin
      zero_frame[i] = 2'b00;
      zero_bits[i]  = 1'b0;
      info[i]       = 1'b0;
    end
    info[0] = 1'b1;
    info[2] = 1'b1;
    info[3] = 1'b1;

    // Pin the model with hand-derived values.
    conv_encode(info, known_frame);
    for (int i = 0; i < 7; i++) check($sformatf("model_encode_sym%0d", i), known_frame[i], lit_syms[i]);
    model_decode(known_frame, dec_bits);
    check("model_known_b0", dec_bits[0], 1);
    check("model_known_b1", dec_bits[1], 0);
    check("model_known_b2", dec_bits[2], 1);
    check("model_known_b3", dec_bits[3], 1);
    for (int i = 4; i < FL; i++) check("model_known_tail", dec_bits[i], 0);
    err_frame    = known_frame;
    err_frame[2] = 2'b10;
    model_decode(err_frame, dec_bits);
    for (int i = 0; i < FL; i++) check("model_err_corrected", dec_bits[i], info[i]);
    model_decode(zero_frame, dec_bits);
    for (int i = 0; i < FL; i++) check("model_zero", dec_bits[i], zero_bits[i]);

    // Reset and post-reset values.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready",  in_ready,  1);
    check("post_reset_out_valid", out_valid, 0);
    check("post_reset_out_bit",   out_bit,   0);
    check("post_reset_out_last",  out_last,  0);
    check("post_reset_busy",      busy,      0);
    @(posedge clk);
    #1;

    // All-zero, known-encode and single-error frames, sink always ready.
    rdy_mode = 0;
    send_frame(zero_frame, 0, 0);
    send_frame(known_frame, 0, 0);
    send_frame(err_frame, 0, 0);
    drain();

    // Back-pressure 1,0,0,1.
    rdy_mode = 1;
    send_frame(known_frame, 0, 0);
    send_frame(err_frame, 0, 1);
    drain();

    // Reset after 15 symbols, then a clean all-zero frame.
    rdy_mode = 0;
    for (int i = 0; i < 15; i++) send_sym(known_frame[i]);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(zero_frame, 0, 0);
    drain();

    // Three idle cycles between every symbol, random sink.
    rdy_mode = 2;
    send_frame(known_frame, 3, 3);
    drain();

    // Random frames with sparse channel errors.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < FL; i++) info[i] = 1'($urandom_range(0, 1));
`ifdef VIT_TERM_EN
      info[FL-2] = 1'b0;
      info[FL-1] = 1'b0;
`endif
      conv_encode(info, rnd_frame);
      if (f < 2) begin
        // Error-free frames must decode to the information bits.
        model_decode(rnd_frame, dec_bits);
        for (int i = 0; i < FL; i++) check("model_clean_random", dec_bits[i], info[i]);
      end else begin
        for (int i = 0; i < FL; i++) begin
          if ($urandom_range(0, 11) == 0) rnd_frame[i] = rnd_frame[i] ^ 2'(1 << $urandom_range(0, 1));
        end
      end
      rdy_mode = f % 3;
      send_frame(rnd_frame, 0, 2);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
